// File: rtl/prng_mon_pkg.sv
// prng_mon_pkg: shared types and helpers for the PRNG period monitor.
//   state_e    - monitor FSM states (IDLE, CAPTURE, MONITOR, FINISH)
//   fp_fields  - splits an N-bit sample into minifloat sign/exponent/mantissa
//   N_DEF, EXP_W_DEF - default sample and exponent widths (8-bit minifloat)
package prng_mon_pkg;

  localparam int N_DEF     = 8;
  localparam int EXP_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    MONITOR = 2'd2,
    FINISH  = 2'd3
  } state_e;

  // Fields are returned right-aligned in 32-bit containers so that one
  // function serves every (N, EXP_W) pairing; callers keep the low bits.
  typedef struct packed {
    logic        sign;
    logic [31:0] exponent;
    logic [31:0] mantissa;
  } fp_fields_t;

  function automatic fp_fields_t fp_fields(input logic [31:0] data,
                                           input int n, input int exp_w);
    fp_fields_t f;
    int man_w;
    man_w      = n - 1 - exp_w;
    f.sign     = data[n-1];
    f.mantissa = data & ((32'd1 << man_w) - 32'd1);
    f.exponent = (data >> man_w) & ((32'd1 << exp_w) - 32'd1);
    return f;
  endfunction

endpackage

// File: rtl/prng_fp_decode.sv
// prng_fp_decode: registered minifloat field split of a sample stream.
// Fields update one cycle after each valid_i and hold otherwise.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   valid_i      - sample strobe
//   data_i[N]    - sample
//   sign_o       - data_i[N-1] of the last valid sample
//   exponent_o   - data_i[N-2:MAN_W] of the last valid sample
//   mantissa_o   - data_i[MAN_W-1:0] of the last valid sample
module prng_fp_decode
  import prng_mon_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int EXP_W = EXP_W_DEF,
  localparam int MAN_W = N - 1 - EXP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [N-1:0]     data_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exponent_o,
  output logic [MAN_W-1:0] mantissa_o
);

  fp_fields_t       f;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] man_q, man_d;

  always_comb f = fp_fields(32'(data_i), N, EXP_W);

  // Upper container bits are always zero after masking.
  logic unused_fields;
  assign unused_fields = ^{f.exponent[31:EXP_W], f.mantissa[31:MAN_W]};

  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    man_d  = man_q;
    if (valid_i) begin
      sign_d = f.sign;
      exp_d  = f.exponent[EXP_W-1:0];
      man_d  = f.mantissa[MAN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      man_q  <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      man_q  <= man_d;
    end
  end

  assign sign_o     = sign_q;
  assign exponent_o = exp_q;
  assign mantissa_o = man_q;

endmodule

// File: rtl/prng_period_monitor.sv
// prng_period_monitor: measures the period of a PRNG output stream.
// After start, the first valid sample is captured; subsequent valid samples
// are counted until that value recurs (period_found) or MAX_CYCLES samples
// pass without recurrence (timeout). done pulses once per completed run.
// Handshake: prng_valid is a one-cycle strobe with no back-pressure; every
// cycle with prng_valid=1 is one sample, cycles with prng_valid=0 are ignored.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   start            - one-cycle arm pulse, restarts from any state
//   prng_valid       - sample strobe
//   prng_data[N]     - sample
//   busy             - high in CAPTURE and MONITOR
//   done             - one-cycle pulse at the end of a run
//   period_found     - sticky: recurrence seen
//   timeout          - sticky: no recurrence within MAX_CYCLES
//   period_len[CW]   - samples from capture to recurrence, or MAX_CYCLES
//   first_value[N]   - captured first sample
//   sign/exponent/mantissa - minifloat fields of the last valid sample
//   dbg_state[2]     - current FSM state (state_e encoding)
//   exp_hist         - per-exponent sample counters, only with
//                      PRNG_MON_HIST_EN defined
module prng_period_monitor
  import prng_mon_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int EXP_W      = EXP_W_DEF,
  parameter int MAX_CYCLES = 300,
  localparam int MAN_W     = N - 1 - EXP_W,
  localparam int CW        = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prng_valid,
  input  logic [N-1:0]     prng_data,
  output logic             busy,
  output logic             done,
  output logic             period_found,
  output logic             timeout,
  output logic [CW-1:0]    period_len,
  output logic [N-1:0]     first_value,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W-1:0] mantissa,
  output logic [1:0]       dbg_state
`ifdef PRNG_MON_HIST_EN
  ,
  output logic [(2**EXP_W)*CW-1:0] exp_hist
`endif
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_next;
  logic [CW-1:0] len_q, len_d;
  logic [N-1:0]  first_q, first_d;
  logic          found_q, found_d;
  logic          tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          sample_match, sample_last;

  assign cnt_next     = cnt_q + CW'(1);
  assign sample_match = (prng_data == first_q);
  assign sample_last  = (cnt_next == MAX_CNT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CAPTURE: if (prng_valid) state_d = MONITOR;
        MONITOR: if (prng_valid && (sample_match || sample_last)) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // done is registered off FINISH so it lands one cycle after the result
  // flags; a start seen while in FINISH cancels it.
  always_comb begin
    busy   = (state_q == CAPTURE) || (state_q == MONITOR);
    done_d = (state_q == FINISH) && !start;
  end

  // ---------------- Datapath ----------------
  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    first_d = first_q;
    found_d = found_q;
    tmo_d   = tmo_q;
    if (start) begin
      cnt_d   = '0;
      len_d   = '0;
      found_d = 1'b0;
      tmo_d   = 1'b0;
    end else if (prng_valid) begin
      if (state_q == CAPTURE) begin
        first_d = prng_data;
        cnt_d   = '0;
      end else if (state_q == MONITOR) begin
        // A match on the final allowed sample counts as found.
        if (sample_match) begin
          len_d   = cnt_next;
          found_d = 1'b1;
        end else if (sample_last) begin
          len_d = MAX_CNT;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      len_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      first_q <= first_d;
      found_q <= found_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

  assign done         = done_q;
  assign period_found = found_q;
  assign timeout      = tmo_q;
  assign period_len   = len_q;
  assign first_value  = first_q;
  assign dbg_state    = state_q;

  // ---------------- Field decode ----------------
  prng_fp_decode #(
    .N     (N),
    .EXP_W (EXP_W)
  ) u_decode (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (prng_valid),
    .data_i     (prng_data),
    .sign_o     (sign),
    .exponent_o (exponent),
    .mantissa_o (mantissa)
  );

`ifdef PRNG_MON_HIST_EN
  // ---------------- Exponent histogram ----------------
  localparam int NBINS = 2**EXP_W;

  logic [CW-1:0]    hist_q [NBINS];
  logic [EXP_W-1:0] hist_idx;
  logic             hist_inc;

  assign hist_idx = prng_data[N-2:MAN_W];
  // The captured sample arrives in CAPTURE, so it is counted there too.
  assign hist_inc = prng_valid && !start &&
                    ((state_q == CAPTURE) || (state_q == MONITOR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBINS; i++) hist_q[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < NBINS; i++) hist_q[i] <= '0;
    end else if (hist_inc && (hist_q[hist_idx] != '1)) begin
      hist_q[hist_idx] <= hist_q[hist_idx] + CW'(1);
    end
  end

  for (genvar g = 0; g < NBINS; g++) begin : g_hist
    assign exp_hist[g*CW +: CW] = hist_q[g];
  end
`endif

endmodule

// File: tb/tb_prng_period_monitor.sv
module tb_prng_period_monitor;

  localparam int N     = 8;
  localparam int EXP_W = 3;
  localparam int MAN_W = N - 1 - EXP_W;
  localparam int MAX   = 300;
  localparam int CW    = 9;
  localparam int NB    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic prng_valid = 1'b0;
  logic [N-1:0] prng_data = '0;

  logic             busy, done, period_found, timeout, sign;
  logic [CW-1:0]    period_len;
  logic [N-1:0]     first_value;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] mantissa;
  logic [1:0]       dbg_state;
`ifdef PRNG_MON_HIST_EN
  logic [NB*CW-1:0] exp_hist;
`endif

  always #5 clk = ~clk;

  prng_period_monitor #(
    .N          (N),
    .EXP_W      (EXP_W),
    .MAX_CYCLES (MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prng_valid   (prng_valid),
    .prng_data    (prng_data),
    .busy         (busy),
    .done         (done),
    .period_found (period_found),
    .timeout      (timeout),
    .period_len   (period_len),
    .first_value  (first_value),
    .sign         (sign),
    .exponent     (exponent),
    .mantissa     (mantissa),
    .dbg_state    (dbg_state)
`ifdef PRNG_MON_HIST_EN
    ,
    .exp_hist     (exp_hist)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // exp_q holds every sample accepted since the run was armed; the period is
  // the index of the first later sample equal to exp_q[0].
  logic [N-1:0] exp_q[$];
  bit           m_active, m_found, m_tmo, m_done, m_pend;
  int           m_len, m_first, m_sign, m_exp, m_man;
  int           m_hist[NB];
  int           done_seen;

  function automatic void model_reset();
    exp_q.delete();
    m_active = 0; m_found = 0; m_tmo = 0; m_done = 0; m_pend = 0;
    m_len = 0; m_first = 0; m_sign = 0; m_exp = 0; m_man = 0;
    for (int i = 0; i < NB; i++) m_hist[i] = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit v, input logic [N-1:0] d);
    bit nd;
    int di, e, idx;
    di = int'(d);
    e  = (di / (1 << MAN_W)) % NB;
    nd = m_pend && !st;
    m_pend = 0;
    if (v) begin
      m_sign = di / (1 << (N - 1));
      m_exp  = e;
      m_man  = di % (1 << MAN_W);
    end
    if (st) begin
      exp_q.delete();
      m_active = 1; m_found = 0; m_tmo = 0; m_len = 0;
      for (int i = 0; i < NB; i++) m_hist[i] = 0;
    end else if (v && m_active) begin
      exp_q.push_back(d);
      if (m_hist[e] < (1 << CW) - 1) m_hist[e]++;
      if (exp_q.size() == 1) begin
        m_first = di;
      end else begin
        idx = exp_q.size() - 1;
        if (d == exp_q[0]) begin
          m_found = 1; m_len = idx; m_active = 0; m_pend = 1;
        end else if (idx == MAX) begin
          m_tmo = 1; m_len = MAX; m_active = 0; m_pend = 1;
        end
      end
    end
    m_done = nd;
  endfunction

  task automatic check_outputs();
`ifdef PRNG_MON_HIST_EN
    logic [NB*CW-1:0] eh;
    for (int i = 0; i < NB; i++) eh[i*CW +: CW] = CW'(m_hist[i]);
    chk("exp_hist", 128'(exp_hist), 128'(eh));
`endif
    chk("busy",         128'(busy),         128'(m_active));
    chk("done",         128'(done),         128'(m_done));
    chk("period_found", 128'(period_found), 128'(m_found));
    chk("timeout",      128'(timeout),      128'(m_tmo));
    chk("period_len",   128'(period_len),   128'(m_len));
    chk("first_value",  128'(first_value),  128'(m_first));
    chk("sign",         128'(sign),         128'(m_sign));
    chk("exponent",     128'(exponent),     128'(m_exp));
    chk("mantissa",     128'(mantissa),     128'(m_man));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit st, input bit v, input logic [N-1:0] d);
    start      = st;
    prng_valid = v;
    prng_data  = d;
    @(posedge clk);
    model_edge(st, v, d);
    #1;
    check_outputs();
    if (done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic smp(input logic [N-1:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; prng_valid = 1'b0; prng_data = '0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    do_reset();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_len",  128'(period_len), 128'(0));
    chk("rst_done", 128'(done), 128'(0));

    // basic period: 42 17 99 42
    done_seen = 0;
    step(1'b1, 1'b0, '0);
    smp(8'd42); smp(8'd17); smp(8'd99); smp(8'd42);
    chk("t1_found_at_k1", 128'(period_found), 128'(1));
    chk("t1_done_not_yet", 128'(done), 128'(0));
    idle(1);
    chk("t1_done_at_k2", 128'(done), 128'(1));
    idle(3);
    chk("t1_first", 128'(first_value), 128'(42));
    chk("t1_len", 128'(period_len), 128'(3));
    chk("t1_tmo", 128'(timeout), 128'(0));
    chk("t1_done_count", 128'(done_seen), 128'(1));

    // timeout: 0 then alternating 1/2
    done_seen = 0;
    step(1'b1, 1'b0, '0);
    smp(8'd0);
    for (int i = 0; i < MAX; i++) smp((i % 2 == 0) ? 8'd1 : 8'd2);
    idle(3);
    chk("t2_tmo", 128'(timeout), 128'(1));
    chk("t2_len", 128'(period_len), 128'(MAX));
    chk("t2_found", 128'(period_found), 128'(0));
    chk("t2_done_count", 128'(done_seen), 128'(1));

    // period 1, back to back and with gaps
    step(1'b1, 1'b0, '0);
    smp(8'd42); smp(8'd42);
    idle(3);
    chk("t3_len", 128'(period_len), 128'(1));
    step(1'b1, 1'b0, '0);
    smp(8'd42); idle(3); smp(8'd42);
    idle(3);
    chk("t3_gap_len", 128'(period_len), 128'(1));
    chk("t3_gap_found", 128'(period_found), 128'(1));

    // restart mid-run, start beats a coincident sample
    step(1'b1, 1'b0, '0);
    smp(8'd42); smp(8'd5); smp(8'd6);
    step(1'b1, 1'b1, 8'd7);
    smp(8'd9); smp(8'd8); smp(8'd9);
    idle(3);
    chk("t4_first", 128'(first_value), 128'(9));
    chk("t4_len", 128'(period_len), 128'(2));

    // start during FINISH suppresses done
    done_seen = 0;
    step(1'b1, 1'b0, '0);
    smp(8'd5); smp(8'd5);
    step(1'b1, 1'b0, '0);
    chk("t5_done_suppressed", 128'(done), 128'(0));
    chk("t5_rearmed_busy", 128'(busy), 128'(1));
    step(1'b1, 1'b0, '0);
    idle(2);
    chk("t5_done_count", 128'(done_seen), 128'(0));

    // field decode
    smp(8'hB5);
    chk("t6_sign", 128'(sign), 128'(1));
    chk("t6_exp", 128'(exponent), 128'(3));
    chk("t6_man", 128'(mantissa), 128'(5));

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      step(1'b1, 1'b0, '0);
      for (int c = 0; c < 40; c++) begin
        step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
             N'($urandom_range(0, 11) * 21));
      end
      idle(2);
    end

    // histogram
    step(1'b1, 1'b0, '0);
    smp(8'h10); smp(8'h13); smp(8'h20); smp(8'h10);
    idle(2);
    smp(8'h30);
`ifdef PRNG_MON_HIST_EN
    chk("t8_hist1", 128'(exp_hist[1*CW +: CW]), 128'(3));
    chk("t8_hist2", 128'(exp_hist[2*CW +: CW]), 128'(1));
    chk("t8_hist3", 128'(exp_hist[3*CW +: CW]), 128'(0));
`endif
    chk("t8_len", 128'(period_len), 128'(3));

    // asynchronous reset in the middle of MONITOR
    step(1'b1, 1'b0, '0);
    smp(8'h81); smp(8'h92); smp(8'hA3);
    chk("t7_busy_before", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    chk("t7_busy",  128'(busy), 128'(0));
    chk("t7_first", 128'(first_value), 128'(0));
    chk("t7_sign",  128'(sign), 128'(0));
    chk("t7_exp",   128'(exponent), 128'(0));
    chk("t7_man",   128'(mantissa), 128'(0));
    chk("t7_done",  128'(done), 128'(0));
`ifdef PRNG_MON_HIST_EN
    chk("t7_hist",  128'(exp_hist), 128'(0));
`endif
    do_reset();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
